jk_register_counter: RTL and testbench

- Parametrised successor to the hct74109 JK flip-flop: a WIDTH-bit bank of 74109-style J/_K flip-flops.
- Adds a global mode controller supporting hold, clear, set, parallel load, up/down count and invert.
- Adds a terminal-count output for cascading.
- Used as the general state/counter register in the CPU datapath wherever a discrete '109/'163 combination was previously wired by hand.

---
 rtl/jk_register_counter_pkg.sv | 29 ++
 rtl/jk_register_counter_ff_cell.sv | 37 +++
 rtl/jk_register_counter.sv | 73 +++++++
 tb/tb_jk_register_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/jk_register_counter_pkg.sv
// Shared definitions for the JK register/counter: mode encodings and the
// per-bit 74109 next-state helper used by the mode controller.
// No logic of its own; imported by the top and cell files.
package jk_register_counter_pkg;

   localparam logic [2:0] MODE_PER_BIT = 3'd0;
   localparam logic [2:0] MODE_HOLD    = 3'd1;
   localparam logic [2:0] MODE_CLEAR   = 3'd2;
   localparam logic [2:0] MODE_SET     = 3'd3;
   localparam logic [2:0] MODE_LOAD    = 3'd4;
   localparam logic [2:0] MODE_COUNT   = 3'd5;
   localparam logic [2:0] MODE_INVERT  = 3'd6;
   localparam logic [2:0] MODE_RSVD    = 3'd7;

   // 74109 J/_K truth table for one bit; unknown J/_K yields X so it is
   // never silently masked into a hold.
   function automatic logic jk_next(input logic q_cur, input logic j_in, input logic k_n_in);
      logic r_res;
      case ({j_in, k_n_in})
         2'b01:   r_res = q_cur;
         2'b00:   r_res = 1'b0;
         2'b11:   r_res = 1'b1;
         2'b10:   r_res = ~q_cur;
         default: r_res = 1'bx;
      endcase
      return r_res;
   endfunction

endpackage

// File: rtl/jk_register_counter_ff_cell.sv
// One 74109-equivalent bit: clocked next-state with async set/clear and reset.
// Outputs follow async inputs immediately; clocked state updates on rising clk.
// No handshake; async set/clear take priority over the clock, reset over all.
module jk_ff_cell
   import jk_register_counter_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_rst_val,
   input  logic i_nxt,
   input  logic i_sd_n,
   input  logic i_rd_n,
   output logic o_q,
   output logic o_q_n
);

   logic r_q;

   // Stored state: reset, then async set/clear, otherwise capture next-state on the edge.
   // When both async inputs are low the stored value is 1, so on release the bit holds 1.
   always_ff @(posedge i_clk or posedge i_rst or negedge i_sd_n or negedge i_rd_n) begin
      if (i_rst)
         r_q <= i_rst_val;
      else if (!i_sd_n)
         r_q <= 1'b1;
      else if (!i_rd_n)
         r_q <= 1'b0;
      else
         r_q <= i_nxt;
   end

   // Level overlay so the outputs track the async pins directly, including the
   // non-complementary both-low case where q and _q are both high.
   assign o_q   = i_rst ? i_rst_val  : (!i_sd_n ? 1'b1 : (!i_rd_n ? 1'b0 : r_q));
   assign o_q_n = i_rst ? ~i_rst_val : (!i_rd_n ? 1'b1 : (!i_sd_n ? 1'b0 : ~r_q));

endmodule

// File: rtl/jk_register_counter.sv
// WIDTH-bit bank of 74109-style flops with a global mode controller and terminal count.
// Latency: q/_q update on the rising clk edge; async set/clear/reset act immediately.
// No backpressure; tc is combinational from mode, cnt_en, up and q for cascading.
module jk_register_counter
   import jk_register_counter_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               PD          = 17
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] _k,
   input  logic [WIDTH-1:0] d,
   input  logic             cnt_en,
   input  logic             up,
   input  logic [WIDTH-1:0] _sd,
   input  logic [WIDTH-1:0] _rd,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] _q,
   output logic             tc
);

   // PD is a modelling parameter only (the RTL is zero-delay); reject nonsense values.
   if (PD <= 0) begin : g_bad_pd
      $error("jk_register_counter: PD must be positive");
   end

   logic [WIDTH-1:0] w_nxt;
   logic [WIDTH-1:0] w_count;

   // Counter arithmetic works on the visible q, so async-forced bits feed the sum
   // as they appear; the cells then override those bits again.
   assign w_count = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));

   // Mode decode into a per-bit next-state request; unknown mode drives X.
   always_comb begin
      w_nxt = q;
      case (mode)
         MODE_PER_BIT: begin
            for (int i = 0; i < WIDTH; i++)
               w_nxt[i] = jk_next(q[i], j[i], _k[i]);
         end
         MODE_HOLD:   w_nxt = q;
         MODE_CLEAR:  w_nxt = '0;
         MODE_SET:    w_nxt = '1;
         MODE_LOAD:   w_nxt = d;
         MODE_COUNT:  w_nxt = cnt_en ? w_count : q;
         MODE_INVERT: w_nxt = ~q;
         MODE_RSVD:   w_nxt = q;
         default:     w_nxt = 'x;
      endcase
   end

   // Terminal count: all ones when counting up, zero when counting down.
   assign tc = (mode == MODE_COUNT) && cnt_en && (up ? (&q) : ~(|q));

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      jk_ff_cell u_cell (
         .i_clk     (clk),
         .i_rst     (reset),
         .i_rst_val (RESET_VALUE[g]),
         .i_nxt     (w_nxt[g]),
         .i_sd_n    (_sd[g]),
         .i_rd_n    (_rd[g]),
         .o_q       (q[g]),
         .o_q_n     (_q[g])
      );
   end

endmodule

// File: tb/tb_jk_register_counter.sv
module tb_jk_register_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] mode;
   logic [7:0] j, k_n, d, sd_n, rd_n;
   logic       cnt_en, up;
   logic [7:0] q, q_n;
   logic       tc;

   int errors = 0;
   int checks = 0;

   always #20 clk = ~clk;

   jk_register_counter #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5),
      .PD          (17)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .mode   (mode),
      .j      (j),
      ._k     (k_n),
      .d      (d),
      .cnt_en (cnt_en),
      .up     (up),
      ._sd    (sd_n),
      ._rd    (rd_n),
      .q      (q),
      ._q     (q_n),
      .tc     (tc)
   );

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle well past the edge before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #5;
   endtask

   initial begin
      reset = 1'b1; mode = 3'd3; j = 8'h00; k_n = 8'hFF; d = 8'h00;
      cnt_en = 1'b0; up = 1'b1; sd_n = 8'hFF; rd_n = 8'hFF;

      // Reset held across edges with mode SET.
      tick(); tick();
      chk8("rst_q", q, 8'hA5);
      chk8("rst_qn", q_n, 8'h5A);
      tick();
      chk8("rst_q_hold", q, 8'hA5);
      reset = 1'b0;
      #2;
      chk8("rst_release_noedge", q, 8'hA5);
      tick();
      chk8("set_q", q, 8'hFF);
      chk8("set_qn", q_n, 8'h00);

      // PER_BIT from 0F: per 74109 table, j=1/_k=0 toggles, j=1/_k=1 sets.
      mode = 3'd4; d = 8'h0F;
      tick();
      chk8("load_0f", q, 8'h0F);
      mode = 3'd0; j = 8'b1100_1010; k_n = 8'b0110_0110;
      tick();
      chk8("per_bit", q, 8'hC6);

      // Count up through wrap, then down.
      mode = 3'd4; d = 8'hFE;
      tick();
      mode = 3'd5; up = 1'b1; cnt_en = 1'b1;
      #1;
      chk8("cnt_start", q, 8'hFE);
      chk1("tc_fe", tc, 1'b0);
      tick();
      chk8("cnt_ff", q, 8'hFF);
      chk1("tc_ff_up", tc, 1'b1);
      tick();
      chk8("cnt_wrap", q, 8'h00);
      chk1("tc_00_up", tc, 1'b0);
      up = 1'b0;
      #1;
      chk1("tc_00_down", tc, 1'b1);
      tick();
      chk8("cnt_down_wrap", q, 8'hFF);
      chk1("tc_ff_down", tc, 1'b0);

      // Count disabled: hold, tc low.
      mode = 3'd4; d = 8'h10;
      tick();
      mode = 3'd5; cnt_en = 1'b0; up = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk8("cnt_dis_q", q, 8'h10);
         chk1("cnt_dis_tc", tc, 1'b0);
      end

      // Async forcing: bit0 set, bit7 clear, visible without a clock.
      mode = 3'd4; d = 8'h3C; sd_n = 8'hFE; rd_n = 8'h7F;
      #1;
      chk8("async_noclk", q, 8'h11);
      tick();
      chk8("load_forced", q, 8'h3D);
      chk8("load_forced_qn", q_n, 8'hC2);
      mode = 3'd1;
      sd_n = 8'hFE; rd_n = 8'h7E;
      #2;
      chk1("both_low_q0", q[0], 1'b1);
      chk1("both_low_qn0", q_n[0], 1'b1);
      chk8("both_low_qn", q_n, 8'hC3);
      sd_n = 8'hFF; rd_n = 8'hFF;
      #2;
      chk8("release_q", q, 8'h3D);
      chk8("release_qn", q_n, 8'hC2);
      tick();
      chk8("release_hold", q, 8'h3D);

      // Reset mid-count without a clock edge.
      mode = 3'd4; d = 8'h41;
      tick();
      mode = 3'd5; cnt_en = 1'b1; up = 1'b1;
      tick();
      chk8("midcnt", q, 8'h42);
      reset = 1'b1;
      #2;
      chk8("midcnt_rst_q", q, 8'hA5);
      chk8("midcnt_rst_qn", q_n, 8'h5A);
      tick();
      chk8("midcnt_rst_edge", q, 8'hA5);
      reset = 1'b0; mode = 3'd6;
      tick();
      chk8("invert_q", q, 8'h5A);
      chk8("invert_qn", q_n, 8'hA5);

      // Reserved mode holds, CLEAR zeroes.
      mode = 3'd7;
      tick();
      chk8("rsvd_hold", q, 8'h5A);
      mode = 3'd2;
      tick();
      chk8("clear", q, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
